capp_word_array: RTL and testbench
==================================

# capp_word_array

Word-storage and tag stage of the content-addressable parallel processor. It sits directly downstream of the comparand/mask match-line generator and consumes its 2×WIDTH match lines. It holds WORDS stored words and evaluates every word against the broadcast match lines in parallel. Results land in a per-word tag register, with first-responder selection, tag counting, an addressed read/write port and a masked multi-write into all tagged words.

## Interface
- WORDS, 16, number of stored words (≥2)
- WIDTH, 32, word width; match-line bus is 2×WIDTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- match_lines  in  2×WIDTH  line 2i = "bit i must be 1", line 2i+1 = "bit i must be 0"
- search_valid  in  1  sample match_lines and update tags this cycle
- tag_op  in  2  0 SET, 1 AND, 2 OR, 3 CLEAR
- select_first  in  1  keep only lowest-indexed set tag
- wr_en  in  1  addressed write
- wr_addr  in  $clog2(WORDS)  write address
- wr_data  in  WIDTH  write data
- mwr_en  in  1  masked write into every tagged word
- mwr_data  in  WIDTH  multi-write data
- mwr_mask  in  WIDTH  1 = bit is written
- rd_addr  in  $clog2(WORDS)  read address
- rd_data  out  WIDTH  registered read data
- tags  out  WORDS  tag register
- any_tag  out  1  OR of tags
- first_idx  out  $clog2(WORDS)  index of lowest set tag; 0 when none
- tag_count  out  $clog2(WORDS+1)  population count of tags

## Operation
- Hit for word w: no bit i with (ml[2i] & !word[i]) | (ml[2i+1] & word[i]). All-zero match lines make every word a hit.
- On search_valid, tags_next[w]:
  - SET: hit
  - AND: tag & hit
  - OR: tag | hit
  - CLEAR: 0
- select_first (without search_valid): tags become one-hot at the lowest set index. No change when tags are all zero.
- search_valid has priority over select_first; select_first is ignored when both are high.
- mwr_en: for every word whose current (pre-update) tag is 1, word = (word & ~mwr_mask) | (mwr_data & mwr_mask).
- wr_en: word[wr_addr] = wr_data. On the same cycle as mwr_en, wr_en wins for that address; mwr applies to the other tagged words.
- A search evaluates pre-write contents; writes in the same cycle are not visible to it.
- rd_data is registered every cycle from rd_addr, using pre-write contents.
- any_tag, first_idx and tag_count are combinational from the tags register.

## Timing
- Reset (async assert, sync-safe deassert by system): all words 0, tags 0, rd_data 0, any_tag 0, first_idx 0, tag_count 0.
- Search latency 1: tags and status are valid the cycle after search_valid.
- select_first latency 1.
- Write latency 1: the written value is visible to search and read on the next cycle.
- rd_data latency 1.
- Back-to-back searches every cycle are supported; each chains on the previous tag result (AND/OR).
- rst_n low mid-sequence clears everything immediately; there is no pending state.
- No handshake or backpressure: every command completes in one cycle.

## Structure
- Shared package capp_pkg:
  - tag_op encoding as a 2-bit enum (TAG_SET, TAG_AND, TAG_OR, TAG_CLEAR)
  - default WIDTH constant, shared with the match-line generator
- Sub-module capp_first_responder:
  - combinational, WORDS wide
  - outputs the one-hot lowest set bit, its index, any and popcount
  - instantiated once on the tags register

## Test plan
- Reset: hold rst_n low, then release. Required: tags=0, any_tag=0, tag_count=0, first_idx=0, rd_data=0.
- Search SET: write words 0..3 = 0x5, 0x7, 0x5, 0xF (others 0); search comparand 0x5, mask 0xF. Required: tags=0x0005, tag_count=2, first_idx=0.
- Chained ops:
  - OR with comparand 0x7, mask 0xF → tags=0x0007.
  - Then AND with bit0=1 only → tags=0x0007.
  - Then AND with bit3=1 → tags=0.
  - Then CLEAR → tags=0.
- select_first:
  - tags=0x000A → 0x0002, first_idx=1.
  - Repeat → unchanged.
  - With tags=0 → stays 0.
  - Together with search_valid SET → search result wins.
- Multi-write: tags=0x0005, mwr_data=0xA, mwr_mask=0xF, simultaneous wr_en addr 2 data 0x3. Required: word0=0xA, word2=0x3, word1=0x7.
- Mid-operation reset: pull rst_n low during back-to-back searches. Required: tags, words and outputs are 0 before the next edge; the first search after release sees all-zero words.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared definitions for the content-addressable parallel processor datapath.
// Holds the tag-update operation encoding and the default word width.
package capp_pkg;

    localparam int CAPP_WIDTH = 32;

    typedef enum logic [1:0] {
        TAG_SET   = 2'd0,
        TAG_AND   = 2'd1,
        TAG_OR    = 2'd2,
        TAG_CLEAR = 2'd3
    } tag_op_e;

endpackage

// File: rtl/capp_first_responder.sv
// Combinational first-responder over a tag vector: lowest set bit as one-hot,
// its index, an any flag and the population count.
module capp_first_responder #(
    parameter int WORDS = 16,
    parameter int IDX_W = $clog2(WORDS),
    parameter int CNT_W = $clog2(WORDS + 1)
) (
    input  logic [WORDS-1:0] vec,
    output logic [WORDS-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        count  = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (vec[i]) begin
                // The first set bit seen in ascending order is the responder.
                if (!any) begin
                    onehot[i] = 1'b1;
                    idx       = IDX_W'(i);
                end
                any   = 1'b1;
                count = count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/capp_word_array.sv
// Word storage and tag stage: parallel match of every stored word against the
// broadcast match lines, tag register update, addressed and masked multi-write.
module capp_word_array
    import capp_pkg::*;
#(
    parameter int WORDS = 16,
    parameter int WIDTH = CAPP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*WIDTH-1:0]         match_lines,
    input  logic                       search_valid,
    input  logic [1:0]                 tag_op,
    input  logic                       select_first,
    input  logic                       wr_en,
    input  logic [$clog2(WORDS)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       mwr_en,
    input  logic [WIDTH-1:0]           mwr_data,
    input  logic [WIDTH-1:0]           mwr_mask,
    input  logic [$clog2(WORDS)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WORDS-1:0]           tags,
    output logic                       any_tag,
    output logic [$clog2(WORDS)-1:0]   first_idx,
    output logic [$clog2(WORDS+1)-1:0] tag_count
);

    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = $clog2(WORDS + 1);

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] must_one;
    logic [WIDTH-1:0] must_zero;
    logic [WORDS-1:0] hit;
    logic [WORDS-1:0] tags_next;
    logic [WORDS-1:0] first_onehot;

    capp_first_responder #(
        .WORDS (WORDS),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_first (
        .vec    (tags),
        .onehot (first_onehot),
        .idx    (first_idx),
        .any    (any_tag),
        .count  (tag_count)
    );

    always_comb begin
        must_one  = '0;
        must_zero = '0;
        for (int i = 0; i < WIDTH; i++) begin
            must_one[i]  = match_lines[2*i];
            must_zero[i] = match_lines[2*i+1];
        end
    end

    // Hit evaluation uses the registered (pre-write) word contents.
    always_comb begin
        hit = '0;
        for (int w = 0; w < WORDS; w++) begin
            hit[w] = ~|((must_one & ~mem[w]) | (must_zero & mem[w]));
        end
    end

    always_comb begin
        tags_next = tags;
        if (search_valid) begin
            case (tag_op_e'(tag_op))
                TAG_SET:   tags_next = hit;
                TAG_AND:   tags_next = tags & hit;
                TAG_OR:    tags_next = tags | hit;
                TAG_CLEAR: tags_next = '0;
                default:   tags_next = tags;
            endcase
        end else if (select_first && any_tag) begin
            tags_next = first_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags    <= '0;
            rd_data <= '0;
        end else begin
            tags    <= tags_next;
            rd_data <= mem[rd_addr];
        end
    end

    // Addressed write overrides the masked multi-write on its own word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WORDS; w++) begin
                mem[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (wr_en && (wr_addr == IDX_W'(w))) begin
                    mem[w] <= wr_data;
                end else if (mwr_en && tags[w]) begin
                    mem[w] <= (mem[w] & ~mwr_mask) | (mwr_data & mwr_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_capp_word_array.sv
// Directed bench for capp_word_array: search ops, first responder, writes, reset.
`timescale 1ns/1ps
module tb_capp_word_array;
    import capp_pkg::*;

    localparam int WORDS = 16;
    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [2*WIDTH-1:0] match_lines;
    logic               search_valid;
    logic [1:0]         tag_op;
    logic               select_first;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               mwr_en;
    logic [WIDTH-1:0]   mwr_data;
    logic [WIDTH-1:0]   mwr_mask;
    logic [3:0]         rd_addr;
    logic [WIDTH-1:0]   rd_data;
    logic [WORDS-1:0]   tags;
    logic               any_tag;
    logic [3:0]         first_idx;
    logic [4:0]         tag_count;

    int n_assert = 0;
    int n_fail   = 0;

    capp_word_array #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .match_lines  (match_lines),
        .search_valid (search_valid),
        .tag_op       (tag_op),
        .select_first (select_first),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .mwr_en       (mwr_en),
        .mwr_data     (mwr_data),
        .mwr_mask     (mwr_mask),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .tags         (tags),
        .any_tag      (any_tag),
        .first_idx    (first_idx),
        .tag_count    (tag_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*WIDTH-1:0] mk_ml(input logic [WIDTH-1:0] comp,
                                                 input logic [WIDTH-1:0] mask);
        logic [2*WIDTH-1:0] ml;
        ml = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                if (comp[i]) ml[2*i] = 1'b1;
                else         ml[2*i+1] = 1'b1;
            end
        end
        return ml;
    endfunction

    task automatic search(input tag_op_e op, input logic [WIDTH-1:0] comp,
                          input logic [WIDTH-1:0] mask);
        match_lines  = mk_ml(comp, mask);
        tag_op       = op;
        search_valid = 1'b1;
        tick();
        search_valid = 1'b0;
        match_lines  = '0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [3:0] a, input logic [WIDTH-1:0] exp);
        rd_addr = a;
        tick();
        chk(name, 64'(rd_data), 64'(exp));
    endtask

    task automatic pulse_select();
        select_first = 1'b1;
        tick();
        select_first = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; match_lines = '0; search_valid = 1'b0; tag_op = 2'd0;
        select_first = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        mwr_en = 1'b0; mwr_data = '0; mwr_mask = '0; rd_addr = '0;

        // Reset
        repeat (3) tick();
        chk("reset_tags_low", 64'(tags), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("reset_tags", 64'(tags), 64'h0);
        chk("reset_any", 64'(any_tag), 64'h0);
        chk("reset_count", 64'(tag_count), 64'h0);
        chk("reset_first", 64'(first_idx), 64'h0);
        chk("reset_rd", 64'(rd_data), 64'h0);

        // Load words and search SET
        write_word(4'd0, 32'h5);
        write_word(4'd1, 32'h7);
        write_word(4'd2, 32'h5);
        write_word(4'd3, 32'hF);
        read_chk("rd_word3", 4'd3, 32'hF);
        search(TAG_SET, 32'h5, 32'hF);
        chk("set_tags", 64'(tags), 64'h0005);
        chk("set_count", 64'(tag_count), 64'd2);
        chk("set_first", 64'(first_idx), 64'd0);
        chk("set_any", 64'(any_tag), 64'd1);

        // Chained operations
        search(TAG_OR, 32'h7, 32'hF);
        chk("or_tags", 64'(tags), 64'h0007);
        chk("or_count", 64'(tag_count), 64'd3);
        search(TAG_AND, 32'h1, 32'h1);
        chk("and_bit0_tags", 64'(tags), 64'h0007);
        search(TAG_AND, 32'h8, 32'h8);
        chk("and_bit3_tags", 64'(tags), 64'h0000);
        chk("and_bit3_any", 64'(any_tag), 64'd0);
        search(TAG_SET, 32'h0, 32'h0);
        chk("allhit_tags", 64'(tags), 64'hFFFF);
        chk("allhit_count", 64'(tag_count), 64'd16);
        search(TAG_CLEAR, 32'h5, 32'hF);
        chk("clear_tags", 64'(tags), 64'h0000);

        // First responder
        search(TAG_SET, 32'h2, 32'h2);
        chk("sf_pre_tags", 64'(tags), 64'h000A);
        pulse_select();
        chk("sf_tags", 64'(tags), 64'h0002);
        chk("sf_first", 64'(first_idx), 64'd1);
        chk("sf_count", 64'(tag_count), 64'd1);
        pulse_select();
        chk("sf_repeat", 64'(tags), 64'h0002);
        search(TAG_CLEAR, 32'h0, 32'h0);
        pulse_select();
        chk("sf_zero", 64'(tags), 64'h0000);
        search(TAG_SET, 32'h2, 32'h2);
        select_first = 1'b1;
        search(TAG_SET, 32'h5, 32'hF);
        select_first = 1'b0;
        chk("sf_search_wins", 64'(tags), 64'h0005);

        // Multi-write with simultaneous addressed write
        mwr_en = 1'b1; mwr_data = 32'hA; mwr_mask = 32'hF;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h3;
        tick();
        mwr_en = 1'b0; wr_en = 1'b0;
        chk("mwr_tags_kept", 64'(tags), 64'h0005);
        read_chk("mwr_word0", 4'd0, 32'hA);
        read_chk("mwr_word1", 4'd1, 32'h7);
        read_chk("mwr_word2", 4'd2, 32'h3);
        read_chk("mwr_word3", 4'd3, 32'hF);

        // Mid-operation reset during back-to-back searches
        match_lines = mk_ml(32'h0, 32'h0); tag_op = TAG_SET; search_valid = 1'b1;
        tick();
        chk("b2b_tags", 64'(tags), 64'hFFFF);
        match_lines = mk_ml(32'hA, 32'hF); tag_op = TAG_AND;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tags", 64'(tags), 64'h0);
        chk("midrst_any", 64'(any_tag), 64'h0);
        chk("midrst_count", 64'(tag_count), 64'h0);
        chk("midrst_rd", 64'(rd_data), 64'h0);
        search_valid = 1'b0; match_lines = '0;
        tick();
        rst_n = 1'b1;
        search(TAG_SET, 32'h0, 32'hF);
        chk("post_rst_search", 64'(tags), 64'hFFFF);
        search(TAG_SET, 32'hA, 32'hF);
        chk("post_rst_search_a", 64'(tags), 64'h0000);
        read_chk("post_rst_word0", 4'd0, 32'h0);
        read_chk("post_rst_word3", 4'd3, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
